grf_mp_sb: RTL and testbench
============================

Name: grf_mp_sb

Overview:
- Parametrised successor to the pipeline general register file: configurable width, depth and number of read ports.
- Two write ports: W-stage writeback (wr0) and long-latency multiply/divide writeback (wr1).
- Per-register pending scoreboard is set at long-latency issue and cleared at wr1 writeback; D-stage hazard logic consumes it.
- Keeps same-cycle internal forwarding (write-through to read ports) and the simulation write trace.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers; AW = $clog2(NREG) address bits.
- NUM_RD, 2, number of read ports.
- FORWARD, 1, 1 = same-cycle write data bypasses to read ports; 0 = reads return stored value only.
- TRACE, 1, 1 = $display each architectural write.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i is slice [i*AW +: AW].
- rd_data  out  NUM_RD*DW  read data, combinational.
- rd_pending  out  NUM_RD  target register of port i awaits wr1.
- wr0_en  in  1  W-stage write enable.
- wr0_addr  in  AW  W-stage destination.
- wr0_data  in  DW  W-stage data.
- wr0_pc  in  32  PC of writing instruction (trace only).
- wr1_en  in  1  long-latency write enable.
- wr1_addr  in  AW  long-latency destination.
- wr1_data  in  DW  long-latency data.
- wr1_pc  in  32  PC for trace.
- issue_en  in  1  long-latency op issues; marks issue_addr pending.
- issue_addr  in  AW  destination of issuing op.
- issue_ready  out  1  issue accepted this cycle.
- pending_cnt  out  AW+1  number of pending registers.

Behaviour:
- Register 0 reads as 0, is never written, and is never pending. Writes or issues to address 0 are ignored; issue to address 0 still reports issue_ready=1.
- Reset (synchronous): all registers = 0, all pending bits = 0, pending_cnt = 0. Reset overrides any same-cycle write or issue. An in-flight long-latency op's later wr1 still writes the register; pending is already clear.
- Writes commit at posedge clk.
- wr0 and wr1 to the same nonzero address in one cycle: wr0 data is stored (younger instruction); wr1 still clears pending.
- Read port i with FORWARD=1 returns, in priority order:
  - wr0_data if wr0_en and wr0_addr==rd_addr and address nonzero;
  - else wr1_data if wr1_en and wr1_addr matches and address nonzero;
  - else the stored value.
- FORWARD=0 returns the stored value only.
- rd_pending[i] = pending[rd_addr_i] AND NOT (FORWARD AND wr1_en AND wr1_addr==rd_addr_i).
- issue_ready = NOT pending[issue_addr] OR (wr1_en AND wr1_addr==issue_addr); combinational.
  - When issue_en is high and issue_ready is low: no state change; the pipeline must stall.
- Pending-bit next state per register r:
  - set if (accepted issue to r);
  - else clear if (wr1_en to r);
  - else hold.
  - Issue and wr1 to the same r in one cycle: bit ends set.
- wr1_en to a non-pending register is legal; data is written and pending is unaffected.
- pending_cnt tracks the popcount of pending bits, registered. It changes by at most ±1 per cycle except when set and clear hit different registers, where the net change is 0. Max value NREG-1.
- TRACE=1: on each committed write to a nonzero register, print "@%h: $%d <= %h" with pc, address, data. wr0 prints before wr1; the wr1 line is suppressed when wr0 hits the same address. No prints during reset.

Decomposition:
- Package grf_pkg holds:
  - default DW/NREG;
  - function addr_w(n) = $clog2(n);
  - localparam ZERO_REG = 0.
- Sub-module grf_scoreboard holds the pending bit vector, issue_ready, pending_cnt and rd_pending. grf_mp_sb instantiates it alongside the storage array and bypass muxes.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data=0, rd_pending=0, pending_cnt=0.
- wr0 writes $5=0x1234ABCD while port0 reads $5 -> same-cycle rd_data0=0x1234ABCD; FORWARD=0 build returns 0 until the next cycle.
- Issue $8, then 3 idle cycles, then wr1 $8=0xDEADBEEF -> rd_pending for $8 is 1 for 3 cycles. In the wr1 cycle rd_pending=0 and rd_data=0xDEADBEEF. pending_cnt goes 0→1→0.
- Issue $8 while $8 pending and no wr1 -> issue_ready=0, pending_cnt unchanged. Same cycle with wr1 $8 -> issue_ready=1, $8 stays pending.
- wr0 $3=0x11 and wr1 $3=0x22 in one cycle -> $3 stores 0x11, read bypass returns 0x11, one trace line only.
- wr0 to $0 with 0xFFFFFFFF plus issue $0 -> $0 reads 0, no pending, no trace; reset asserted mid-pending clears pending_cnt to 0 next cycle.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared defaults and helpers for the multi-port general register file.
package grf_pkg;

    localparam int unsigned DEFAULT_DW   = 32;
    localparam int unsigned DEFAULT_NREG = 32;
    localparam int unsigned ZERO_REG     = 0;

    function automatic int unsigned addr_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending scoreboard for long-latency destinations.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter  int unsigned NREG    = DEFAULT_NREG,
    parameter  int unsigned NUM_RD  = 2,
    parameter  int unsigned FORWARD = 1,
    localparam int unsigned AW      = addr_w(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_pending,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    output logic                 issue_ready,
    output logic [AW:0]          pending_cnt
);

    localparam bit FWD = (FORWARD != 0);

    logic [NREG-1:0] pending_q, pending_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            wr1_hit, accept, inc, dec;

    always_comb begin
        wr1_hit     = wr1_en && (wr1_addr != AW'(ZERO_REG));
        issue_ready = !pending_q[issue_addr] || (wr1_en && (wr1_addr == issue_addr));
        accept      = issue_en && issue_ready && (issue_addr != AW'(ZERO_REG));
        // A same-register issue and wr1 leaves the bit set, so neither counts.
        inc         = accept && !pending_q[issue_addr];
        dec         = wr1_hit && pending_q[wr1_addr] && !(accept && (issue_addr == wr1_addr));
        pending_d   = pending_q;
        if (wr1_hit) pending_d[wr1_addr] = 1'b0;
        if (accept)  pending_d[issue_addr] = 1'b1;
        cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rdp
        logic [AW-1:0] a;
        assign a             = rd_addr[i*AW +: AW];
        assign rd_pending[i] = pending_q[a] && !(FWD && wr1_en && (wr1_addr == a));
    end

endmodule

// File: rtl/grf_mp_sb.sv
// Multi-read-port register file with two write ports, same-cycle bypass
// and a pending scoreboard for long-latency writebacks.
module grf_mp_sb
    import grf_pkg::*;
#(
    parameter  int unsigned DW      = DEFAULT_DW,
    parameter  int unsigned NREG    = DEFAULT_NREG,
    parameter  int unsigned NUM_RD  = 2,
    parameter  int unsigned FORWARD = 1,
    parameter  int unsigned TRACE   = 1,
    localparam int unsigned AW      = addr_w(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_pending,
    input  logic                 wr0_en,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [DW-1:0]        wr0_data,
    input  logic [31:0]          wr0_pc,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [DW-1:0]        wr1_data,
    input  logic [31:0]          wr1_pc,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    output logic                 issue_ready,
    output logic [AW:0]          pending_cnt
);

    localparam bit FWD = (FORWARD != 0);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          wr0_hit, wr1_hit;

    assign wr0_hit = wr0_en && (wr0_addr != AW'(ZERO_REG));
    assign wr1_hit = wr1_en && (wr1_addr != AW'(ZERO_REG));

    // wr0 is applied last so the younger instruction wins an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr1_hit) regs_d[wr1_addr] = wr1_data;
        if (wr0_hit) regs_d[wr0_addr] = wr0_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < int'(NREG); r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] rdata_c;
        assign a = rd_addr[i*AW +: AW];
        always_comb begin
            rdata_c = regs_q[a];
            if (FWD && wr0_hit && (wr0_addr == a))      rdata_c = wr0_data;
            else if (FWD && wr1_hit && (wr1_addr == a)) rdata_c = wr1_data;
        end
        assign rd_data[i*DW +: DW] = rdata_c;
    end

    grf_scoreboard #(
        .NREG    (NREG),
        .NUM_RD  (NUM_RD),
        .FORWARD (FORWARD)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_pending  (rd_pending),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .pending_cnt (pending_cnt)
    );

    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (!reset) begin
                if (wr0_hit) $display("@%h: $%d <= %h", wr0_pc, wr0_addr, wr0_data);
                if (wr1_hit && !(wr0_hit && (wr0_addr == wr1_addr)))
                    $display("@%h: $%d <= %h", wr1_pc, wr1_addr, wr1_data);
            end
        end
    end else begin : g_notrace
        logic unused_pc;
        assign unused_pc = ^{wr0_pc, wr1_pc};
    end

endmodule

// File: tb/tb_grf_mp_sb.sv
// Scoreboard bench for grf_mp_sb: a forwarding instance and a FORWARD=0 instance share stimulus.
module tb_grf_mp_sb;

    localparam int unsigned AW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra0, ra1;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, nf_rd_data;
    logic [1:0]  rd_pending, nf_rd_pending;
    logic        wr0_en, wr1_en, issue_en, issue_ready, nf_issue_ready;
    logic [4:0]  wr0_addr, wr1_addr, issue_addr;
    logic [31:0] wr0_data, wr1_data, wr0_pc, wr1_pc;
    logic [5:0]  pending_cnt, nf_pending_cnt;

    always #5 clk = ~clk;
    assign rd_addr = {ra1, ra0};

    grf_mp_sb u_dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_pc(wr0_pc),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_pc(wr1_pc),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .pending_cnt(pending_cnt)
    );

    grf_mp_sb #(.FORWARD(0), .TRACE(0)) u_nf (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nf_rd_data), .rd_pending(nf_rd_pending),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_pc(wr0_pc),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_pc(wr1_pc),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(nf_issue_ready),
        .pending_cnt(nf_pending_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd0, rd1, nf0, nf1;
        logic [1:0]  rdp, nfp;
        logic        ir;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic        m_pend [32];
    int          m_cnt;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit fwd);
        if (fwd && wr0_en && wr0_addr == a && a != 5'd0) return wr0_data;
        if (fwd && wr1_en && wr1_addr == a && a != 5'd0) return wr1_data;
        return m_regs[a];
    endfunction

    function automatic logic m_ready();
        return !m_pend[issue_addr] || (wr1_en && wr1_addr == issue_addr);
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.rd0 = m_read(ra0, 1'b1);
        e.rd1 = m_read(ra1, 1'b1);
        e.nf0 = m_read(ra0, 1'b0);
        e.nf1 = m_read(ra1, 1'b0);
        e.rdp = {m_pend[ra1] && !(wr1_en && wr1_addr == ra1), m_pend[ra0] && !(wr1_en && wr1_addr == ra0)};
        e.nfp = {m_pend[ra1], m_pend[ra0]};
        e.ir  = m_ready();
        e.cnt = 6'(m_cnt);
        sb_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".rd0"}, rd_data[31:0], e.rd0);
            chk({e.tag, ".rd1"}, rd_data[63:32], e.rd1);
            chk({e.tag, ".nf0"}, nf_rd_data[31:0], e.nf0);
            chk({e.tag, ".nf1"}, nf_rd_data[63:32], e.nf1);
            chk({e.tag, ".rdp"}, 32'(rd_pending), 32'(e.rdp));
            chk({e.tag, ".nfp"}, 32'(nf_rd_pending), 32'(e.nfp));
            chk({e.tag, ".ir"}, 32'(issue_ready), 32'(e.ir));
            chk({e.tag, ".nfir"}, 32'(nf_issue_ready), 32'(e.ir));
            chk({e.tag, ".cnt"}, 32'(pending_cnt), 32'(e.cnt));
            chk({e.tag, ".nfcnt"}, 32'(nf_pending_cnt), 32'(e.cnt));
        end
    endtask

    task automatic commit();
        logic acc;
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            acc = issue_en && m_ready() && issue_addr != 5'd0;
            if (wr1_en && wr1_addr != 5'd0) begin
                m_regs[wr1_addr] = wr1_data;
                m_pend[wr1_addr] = 1'b0;
            end
            if (wr0_en && wr0_addr != 5'd0) m_regs[wr0_addr] = wr0_data;
            if (acc) m_pend[issue_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int r = 0; r < 32; r++) m_cnt += int'(m_pend[r]);
        #1;
    endtask

    task automatic cyc(input string tag);
        push_exp(tag);
        sample();
        commit();
    endtask

    task automatic idle();
        reset = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; issue_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr0_en = 0; wr1_en = 0; issue_en = 0;
        wr0_addr = 0; wr1_addr = 0; issue_addr = 0; ra0 = 0; ra1 = 0;
        wr0_data = 0; wr1_data = 0; wr0_pc = 32'h100; wr1_pc = 32'h200;
        commit();
        commit();
        idle();

        // reset state on every address
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a); ra1 = 5'(31 - a);
            cyc("rst_read");
        end
        chk("rst_cnt", 32'(pending_cnt), 32'd0);

        // wr0 bypass vs stored read
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234ABCD; ra0 = 5; ra1 = 0;
        push_exp("wr0_fwd"); sample();
        chk("wr0_fwd_rd0", rd_data[31:0], 32'h1234ABCD);
        chk("wr0_nofwd_rd0", nf_rd_data[31:0], 32'h0);
        commit();
        idle();
        push_exp("wr0_next"); sample();
        chk("wr0_next_nf0", nf_rd_data[31:0], 32'h1234ABCD);
        commit();

        // issue $8, three idle cycles, then wr1
        issue_en = 1; issue_addr = 8; ra0 = 8;
        cyc("iss8");
        idle();
        for (int k = 0; k < 3; k++) begin
            push_exp("wait8"); sample();
            chk("wait8_pend", 32'(rd_pending[0]), 32'd1);
            chk("wait8_cnt", 32'(pending_cnt), 32'd1);
            commit();
        end
        wr1_en = 1; wr1_addr = 8; wr1_data = 32'hDEADBEEF;
        push_exp("wr1_8"); sample();
        chk("wr1_8_pend", 32'(rd_pending[0]), 32'd0);
        chk("wr1_8_rd0", rd_data[31:0], 32'hDEADBEEF);
        chk("wr1_8_nfpend", 32'(nf_rd_pending[0]), 32'd1);
        commit();
        idle();
        push_exp("after8"); sample();
        chk("after8_cnt", 32'(pending_cnt), 32'd0);
        commit();

        // issue stall and issue racing wr1
        issue_en = 1; issue_addr = 8;
        cyc("iss8b");
        push_exp("stall8"); sample();
        chk("stall8_ir", 32'(issue_ready), 32'd0);
        commit();
        idle();
        push_exp("stall8_after"); sample();
        chk("stall8_cnt", 32'(pending_cnt), 32'd1);
        commit();
        issue_en = 1; issue_addr = 8; wr1_en = 1; wr1_addr = 8; wr1_data = 32'h55;
        push_exp("race8"); sample();
        chk("race8_ir", 32'(issue_ready), 32'd1);
        commit();
        idle();
        push_exp("race8_after"); sample();
        chk("race8_pend", 32'(rd_pending[0]), 32'd1);
        chk("race8_cnt", 32'(pending_cnt), 32'd1);
        commit();
        wr1_en = 1; wr1_addr = 8; wr1_data = 32'h66;
        cyc("clr8");
        idle();

        // wr0 and wr1 collide on $3
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22; ra0 = 3; ra1 = 3;
        push_exp("col3"); sample();
        chk("col3_rd0", rd_data[31:0], 32'h11);
        commit();
        idle();
        push_exp("col3_next"); sample();
        chk("col3_nf0", nf_rd_data[31:0], 32'h11);
        commit();

        // register zero and reset while pending
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; issue_en = 1; issue_addr = 0; ra0 = 0; ra1 = 0;
        push_exp("zero"); sample();
        chk("zero_ir", 32'(issue_ready), 32'd1);
        commit();
        idle();
        push_exp("zero_next"); sample();
        chk("zero_rd0", rd_data[31:0], 32'h0);
        chk("zero_cnt", 32'(pending_cnt), 32'd0);
        commit();
        issue_en = 1; issue_addr = 9; ra0 = 9;
        cyc("iss9");
        idle();
        push_exp("pend9"); sample();
        chk("pend9_cnt", 32'(pending_cnt), 32'd1);
        commit();
        reset = 1; issue_en = 1; issue_addr = 10;
        cyc("rst_mid");
        idle();
        push_exp("rst_after"); sample();
        chk("rst_after_cnt", 32'(pending_cnt), 32'd0);
        chk("rst_after_pend", 32'(rd_pending[0]), 32'd0);
        commit();
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h77;
        cyc("late9");
        idle();
        push_exp("late9_rd"); sample();
        chk("late9_rd0", rd_data[31:0], 32'h77);
        commit();

        // random mix on a small address range for frequent collisions
        for (int n = 0; n < 300; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            wr0_en     = 1'($urandom_range(0, 1));
            wr1_en     = 1'($urandom_range(0, 1));
            issue_en   = 1'($urandom_range(0, 1));
            wr0_addr   = 5'($urandom_range(0, 7));
            wr1_addr   = 5'($urandom_range(0, 7));
            issue_addr = 5'($urandom_range(0, 7));
            ra0        = 5'($urandom_range(0, 7));
            ra1        = 5'($urandom_range(0, 7));
            wr0_data   = $urandom;
            wr1_data   = $urandom;
            cyc("rand");
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
